// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add over WIDTH/4 passes of one rca_4bit.
// Optional add/sub mode with signed overflow: NIBBLE_SERIAL_ADDER_ADDSUB_EN.

// Four full adders chained; the one slice the sequencer reuses every pass.
module rca_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i])
                  | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [IW-1:0]    idx;

  logic [IW+1:0]    base;
  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic [3:0]       sl_s;
  logic             sl_co;
  logic             last;
  logic             accept;

  logic [WIDTH-1:0] b_in;
  logic             c_in;

  // Status outputs decode straight from state so reset forces them at once.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

  assign accept = in_valid & in_ready;

  // Subtraction is a + ~b + 1, so the operand is inverted once at capture.
`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  // Nibble selected by the pass index feeds the shared slice.
  assign base = {idx, 2'b00};
  assign sl_a = a_reg[base +: 4];
  assign sl_b = b_reg[base +: 4];
  assign last = (idx == IW'(N - 1));

  rca_4bit u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_reg),
    .s    (sl_s),
    .cout (sl_co)
  );

  // Sequencer: capture, one nibble per cycle, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b_in;
            carry_reg <= c_in;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_reg[base +: 4] <= sl_s;
          carry_reg          <= sl_co;
          if (last) begin
            cout_reg <= sl_co;
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
  logic ovf_reg;
  logic a_msb;
  logic b_msb;

  assign a_msb = a_reg[WIDTH-1];
  assign b_msb = b_reg[WIDTH-1];
  assign ovf   = ovf_reg;

  // Signed overflow taken from the MSB slice alongside the final carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_reg <= (a_msb == b_msb)
               & (sl_s[3] != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed-vector bench for the serial adder.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
  logic         sub;
  logic         ovf;
`endif

  int vectors    = 0;
  int miscompares = 0;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
    .sub       (sub),
    .ovf       (ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands and take the acceptance edge.
  task automatic issue(input logic [W-1:0] va,
                       input logic [W-1:0] vb,
                       input logic vc);
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = 1'b1;
    chk("pre_accept_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    a        = ~va;
    b        = 16'h5A5A;
    cin      = ~vc;
    chk("post_accept_busy", 32'(busy), 32'd1);
  endtask

  // Walk the N passes, then check the held result.
  task automatic finish(input string tag,
                        input logic [W-1:0] es,
                        input logic ec);
    for (int i = 1; i < N; i++) begin
      chk({tag, "_run_ov"}, 32'(out_valid), 32'd0);
      chk({tag, "_run_ir"}, 32'(in_ready), 32'd0);
      step();
    end
    chk({tag, "_pre_ov"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_ov"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("drain_ov", 32'(out_valid), 32'd0);
    chk("drain_ir", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [W-1:0] ta [3];
    logic [W-1:0] tb_ [3];
    logic [W-1:0] ts [3];
    logic         tc [3];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
    sub       = 1'b0;
`endif
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Basic add; latency N, in_ready low throughout.
    issue(16'h1234, 16'h4321, 1'b0);
    finish("add1", 16'h5555, 1'b0);
    chk("add1_ir_done", 32'(in_ready), 32'd0);
    drain();

    // Carry ripples through every pass.
    issue(16'hFFFF, 16'h0001, 1'b0);
    finish("carry", 16'h0000, 1'b1);
    drain();

    issue(16'h0000, 16'h0000, 1'b1);
    finish("cin", 16'h0001, 1'b0);
    drain();

    // Backpressure: held result, second request not taken.
    issue(16'h1234, 16'h4321, 1'b0);
    finish("bp", 16'h5555, 1'b0);
    a        = 16'h1111;
    b        = 16'h1111;
    cin      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_ov", 32'(out_valid), 32'd1);
      chk("bp_hold_sum", 32'(sum), 32'h5555);
      chk("bp_hold_cout", 32'(cout), 32'd0);
      chk("bp_hold_ir", 32'(in_ready), 32'd0);
    end
    drain();
    step();
    chk("bp2_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    finish("bp2", 16'h2222, 1'b0);
    drain();

    // Back-to-back with both handshakes held high.
    ta[0] = 16'h0001; tb_[0] = 16'h0002; ts[0] = 16'h0003; tc[0] = 1'b0;
    ta[1] = 16'hABCD; tb_[1] = 16'h1111; ts[1] = 16'hBCDE; tc[1] = 1'b0;
    ta[2] = 16'h8000; tb_[2] = 16'h8000; ts[2] = 16'h0000; tc[2] = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cin       = 1'b0;
    for (int j = 0; j < 3; j++) begin
      a = ta[j];
      b = tb_[j];
      n = 0;
      while (!in_ready && n < 20) begin
        step();
        n++;
      end
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      step();
      n = 0;
      while (!out_valid && n < 20) begin
        step();
        n++;
      end
      chk("b2b_latency", 32'(n), 32'(N));
      chk("b2b_sum", 32'(sum), 32'(ts[j]));
      chk("b2b_cout", 32'(cout), 32'(tc[j]));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("b2b_idle", 32'(in_ready), 32'd1);

    // Asynchronous reset during the second RUN cycle.
    issue(16'h1234, 16'h4321, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    issue(16'h00FF, 16'h0001, 1'b0);
    finish("post_rst", 16'h0100, 1'b0);
    drain();

`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
    sub = 1'b1;
    issue(16'h0005, 16'h0007, 1'b0);
    finish("sub1", 16'hFFFE, 1'b0);
    chk("sub1_ovf", 32'(ovf), 32'd0);
    drain();
    issue(16'h8000, 16'h0001, 1'b0);
    finish("sub2", 16'h7FFF, 1'b1);
    chk("sub2_ovf", 32'(ovf), 32'd1);
    drain();
    sub = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
